// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA storage read engine.
package vga_pkg;

    localparam int unsigned DW_PIX = 24;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_t;

    // Final burst index N-1 for N = 2^min(sel, maw)
    function automatic int unsigned burst_max(input logic [3:0] sel, input int unsigned maw);
        int unsigned s;
        s = (32'(sel) > maw) ? maw : 32'(sel);
        return (32'd1 << s) - 32'd1;
    endfunction

endpackage

// File: rtl/vga_line_reader_if.sv
// Pixel stream toward the scan-out pipeline (valid/ready with last marker).
interface vga_line_reader_if
    import vga_pkg::*;
#(
    parameter int unsigned DW = DW_PIX
);
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_last;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_last,
        output pix_ready
    );
endinterface

// File: rtl/vga_line_reader_rd_skid_fifo.sv
// First-word-fall-through FIFO with occupancy count; buffers RAM read data.
module rd_skid_fifo #(
    parameter int unsigned DW    = 25,
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [DW-1:0]                head_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

    // Storage, pointers and occupancy; the caller never pushes when full or pops when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vga_line_reader.sv
// Read-side engine for the VGA storage RAM: sweeps addresses 0..N-1 and streams
// the fixed-latency read data out with full backpressure.
module vga_line_reader
    import vga_pkg::*;
#(
    parameter int unsigned MAW    = 10,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned DW     = DW_PIX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_start,
    input  logic [3:0]        sel_addr_wth,
    output logic [MAW-1:0]    rd_vga_addr,
    input  logic [DW-1:0]     q_a,
    vga_line_reader_if.master pix,
    output logic              busy,
    output logic              done
);
    localparam int unsigned DEPTH = RD_LAT + 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    rd_state_t         state;
    logic [MAW-1:0]    max_addr;
    logic [MAW-1:0]    issue_cnt;
    logic [RD_LAT-1:0] vpipe;
    logic [RD_LAT-1:0] lpipe;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [DW:0]       head;
    logic              push;
    logic              pop;
    logic              can_issue;
    logic              issue;
    int unsigned       occupancy;

    assign push          = vpipe[RD_LAT-1];
    assign pop           = pix.pix_valid & pix.pix_ready;
    assign pix.pix_valid = ~fifo_empty;
    assign pix.pix_data  = head[DW-1:0];
    assign pix.pix_last  = ~fifo_empty & head[DW];

    // Credit check: buffered plus in-flight words, a same-cycle pop frees one slot
    always_comb begin
        occupancy = 32'(fifo_count) + unsigned'($countones(vpipe)) - 32'(pop);
        can_issue = (occupancy < DEPTH);
        issue     = (state == ISSUE) && can_issue;
    end

    // Burst control: latch length, issue addresses under credit, finish on last accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            max_addr    <= '0;
            issue_cnt   <= '0;
            rd_vga_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        max_addr  <= MAW'(burst_max(sel_addr_wth, MAW));
                        issue_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (can_issue) begin
                        rd_vga_addr <= issue_cnt;
                        issue_cnt   <= issue_cnt + MAW'(1);
                        if (issue_cnt == max_addr) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head[DW] && (vpipe == '0)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue-valid and last-flag delay line matching the RAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe <= '0;
            lpipe <= '0;
        end else begin
            vpipe <= (vpipe << 1) | RD_LAT'(issue);
            lpipe <= (lpipe << 1) | RD_LAT'(issue && (issue_cnt == max_addr));
        end
    end

    rd_skid_fifo #(
        .DW    (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({lpipe[RD_LAT-1], q_a}),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_vga_line_reader.sv
// Testbench for vga_line_reader: randomized bursts and backpressure checked
// against a burst-level queue model of the expected pixel stream.
module tb_vga_line_reader;
    localparam int unsigned MAW    = 10;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DW     = 24;
    localparam logic [DW-1:0] BASE = 24'h100000;

    logic           clk = 1'b0;
    logic           rst;
    logic           rd_start;
    logic [3:0]     sel_addr_wth;
    logic [MAW-1:0] rd_vga_addr;
    logic [DW-1:0]  q_a;
    logic           busy;
    logic           done;

    vga_line_reader_if #(.DW(DW)) pix ();

    vga_line_reader #(
        .MAW    (MAW),
        .RD_LAT (RD_LAT),
        .DW     (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_start     (rd_start),
        .sel_addr_wth (sel_addr_wth),
        .rd_vga_addr  (rd_vga_addr),
        .q_a          (q_a),
        .pix          (pix),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, mem[i] = BASE + i; the DUT's address register plus this
    // output register give the two-clock read latency.
    always @(posedge clk) q_a <= BASE + DW'(rd_vga_addr);

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;
    int phase = 0;

    logic [DW:0]   exp_q [$];
    logic [DW-1:0] acc_hist [$];
    bit  m_busy = 1'b0;
    bit  m_done = 1'b0;
    bit  wait_first = 1'b0;
    int  start_cyc = 0;
    int  first_valid_cyc = 0;
    int  done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every-cycle comparison against the burst model, then model update for the coming edge
    always @(negedge clk) begin
        bit last_acc;
        int unsigned s;
        int unsigned n;
        if (rst) begin
            chk("rst_valid", 32'(pix.pix_valid), 32'd0);
            chk("rst_data",  32'(pix.pix_data),  32'd0);
            chk("rst_busy",  32'(busy),          32'd0);
            chk("rst_addr",  32'(rd_vga_addr),   32'd0);
            exp_q.delete();
            m_busy     = 1'b0;
            m_done     = 1'b0;
            wait_first = 1'b0;
        end else begin
            last_acc = 1'b0;
            chk("fifo_bound", 32'(dut.fifo_count <= (RD_LAT + 1)), 32'd1);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            if (done) done_cyc = cyc;
            if (pix.pix_valid) begin
                if (wait_first) begin
                    chk("first_latency", 32'(cyc - start_cyc), RD_LAT + 1);
                    wait_first      = 1'b0;
                    first_valid_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat: got data %h, required no beat", pix.pix_data);
                end else begin
                    chk("beat", 32'({pix.pix_last, pix.pix_data}), 32'(exp_q[0]));
                    if (pix.pix_ready) begin
                        last_acc = exp_q[0][DW];
                        acc_hist.push_back(pix.pix_data);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_last", 32'(pix.pix_last), 32'd0);
            end
            m_done = last_acc;
            if (last_acc) m_busy = 1'b0;
            if (rd_start && !m_busy) begin
                s = 32'(sel_addr_wth);
                if (s > MAW) s = MAW;
                n = 32'd1 << s;
                for (int unsigned i = 0; i < n; i++) begin
                    exp_q.push_back({(i == n - 1), BASE + DW'(i)});
                end
                m_busy     = 1'b1;
                wait_first = 1'b1;
                start_cyc  = cyc + 1;
            end
        end
    end

    // Downstream ready: 0 = always, 1 = 1,0,0,1 pattern, 2 = random
    initial begin
        pix.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       pix.pix_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
                2:       pix.pix_ready = 1'($urandom_range(0, 1));
                default: pix.pix_ready = 1'b1;
            endcase
            phase++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int sel);
        rd_start     = 1'b1;
        sel_addr_wth = 4'(sel);
        tick();
        rd_start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
        end
    endtask

    task automatic run_burst(input int sel, input int mode, output int b0, output int beats);
        ready_mode = mode;
        b0 = acc_hist.size();
        start(sel);
        wait_done(5000);
        beats = acc_hist.size() - b0;
    endtask

    initial begin
        int b0;
        int b1;
        int beats;
        int sel;
        int n;
        rst          = 1'b0;
        rd_start     = 1'b0;
        sel_addr_wth = '0;
        #1 rst = 1'b1;
        #1;
        chk("init_valid", 32'(pix.pix_valid), 32'd0);
        chk("init_last",  32'(pix.pix_last),  32'd0);
        chk("init_busy",  32'(busy),          32'd0);
        chk("init_done",  32'(done),          32'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // sel=3, full throughput
        run_burst(3, 0, b0, beats);
        chk("s3_beats", 32'(beats), 32'd8);
        chk("s3_first", 32'(acc_hist[b0]), 32'h100000);
        chk("s3_lastd", 32'(acc_hist[b0 + 7]), 32'h100007);
        chk("s3_addr",  32'(rd_vga_addr), 32'h7);
        @(negedge clk);
        #1;
        chk("s3_rate", 32'(done_cyc - first_valid_cyc), 32'd8);
        repeat (2) tick();

        // sel=0, single beat
        run_burst(0, 0, b0, beats);
        chk("s0_beats", 32'(beats), 32'd1);
        chk("s0_data",  32'(acc_hist[b0]), 32'h100000);
        chk("s0_addr",  32'(rd_vga_addr), 32'h0);
        repeat (2) tick();

        // sel=4, ready 1,0,0,1
        run_burst(4, 1, b0, beats);
        chk("s4p_beats", 32'(beats), 32'd16);
        chk("s4p_lastd", 32'(acc_hist[b0 + 15]), 32'h10000F);
        repeat (2) tick();

        // sel=12 clamps to 1024 beats
        run_burst(12, 0, b0, beats);
        chk("s12_beats", 32'(beats), 32'd1024);
        chk("s12_addr",  32'(rd_vga_addr), 32'h3FF);
        chk("s12_lastd", 32'(acc_hist[b0 + 1023]), 32'h1003FF);
        repeat (2) tick();

        // rd_start pulses while busy are ignored
        ready_mode = 2;
        b0 = acc_hist.size();
        start(4);
        repeat (3) tick();
        start(1);
        repeat (4) tick();
        start(6);
        wait_done(5000);
        chk("ign_beats", 32'(acc_hist.size() - b0), 32'd16);

        // rd_start in the done cycle starts a new burst
        ready_mode = 0;
        repeat (2) tick();
        start(2);
        wait_done(5000);
        rd_start     = 1'b1;
        sel_addr_wth = 4'd3;
        tick();
        rd_start     = 1'b0;
        b1 = acc_hist.size();
        wait_done(5000);
        chk("rs_beats", 32'(acc_hist.size() - b1), 32'd8);
        chk("rs_first", 32'(acc_hist[b1]), 32'h100000);
        repeat (2) tick();

        // Async reset after beat 5 of a sel=4 burst
        b0 = acc_hist.size();
        start(4);
        n = 0;
        while ((acc_hist.size() - b0) < 5 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_reach5", 32'(acc_hist.size() - b0 >= 5), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(pix.pix_valid), 32'd0);
        chk("arst_data",  32'(pix.pix_data),  32'd0);
        chk("arst_last",  32'(pix.pix_last),  32'd0);
        chk("arst_busy",  32'(busy),          32'd0);
        chk("arst_addr",  32'(rd_vga_addr),   32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_burst(4, 0, b0, beats);
        chk("post_beats", 32'(beats), 32'd16);
        chk("post_first", 32'(acc_hist[b0]), 32'h100000);
        repeat (2) tick();

        // Randomized bursts and backpressure
        for (int k = 0; k < 10; k++) begin
            sel = int'($urandom_range(0, 6));
            n   = 1 << sel;
            run_burst(sel, int'($urandom_range(0, 2)), b0, beats);
            chk("rnd_beats", 32'(beats), 32'(n));
            chk("rnd_lastd", 32'(acc_hist[b0 + n - 1]), 32'(BASE) + 32'(n - 1));
            chk("rnd_addr",  32'(rd_vga_addr), 32'(n - 1));
            repeat (int'($urandom_range(0, 3))) tick();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_line_reader.md
Name: vga_line_reader

Overview:
- Read-side engine for the VGA storage RAM. On a start pulse it sweeps the read address from 0 to 2^sel_addr_wth - 1 and captures the RAM's fixed-latency read data.
- It presents the pixels as a valid/ready stream toward the scan-out/pixel pipeline, with full backpressure support.
- It is the consumer counterpart of the burst writer that fills the same RAM.

Parameters:
- MAW, 10, RAM address width; max burst is 2^MAW words.
- RD_LAT, 2, RAM read latency in clocks from rd_vga_addr sampled to q_a valid; must be >= 1.
- DW, 24, pixel/RAM data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rd_start  in  1  one-cycle pulse; begins a burst (ignored while busy).
- sel_addr_wth  in  4  burst length select; N = 2^min(sel_addr_wth, MAW); latched at rd_start.
- rd_vga_addr  out  MAW  registered read address to the storage block.
- q_a  in  DW  RAM read data.
- pix_data  out  DW  stream data.
- pix_valid  out  1  stream valid.
- pix_ready  in  1  stream ready from downstream.
- pix_last  out  1  high with the final beat (index N-1).
- busy  out  1  high from the cycle after rd_start until done.
- done  out  1  one-cycle pulse, the cycle after the last beat is accepted.

Behaviour:
- Reset (async, any time, including mid-burst) clears all state immediately:
  - rd_vga_addr=0, pix_valid=0, pix_last=0, busy=0, done=0, pix_data=0.
  - FSM goes to IDLE; FIFO is emptied; in-flight reads are discarded.
- FSM has three states.
  - IDLE: on rd_start, latch N-1 as max_addr = ~({MAW{1}} << sel) (sel clamped to MAW), clear issue_cnt, go to ISSUE, busy=1 next cycle.
  - ISSUE: each cycle with credit available, drive rd_vga_addr=issue_cnt (registered) and shift a 1 into the valid pipeline. When issue_cnt==max_addr is issued, go to DRAIN.
  - DRAIN: wait until the valid pipeline and FIFO are empty and the last beat is accepted, then go to IDLE and pulse done. busy deasserts in the same cycle as done.
- Read pipeline:
  - RD_LAT-deep shift register of issue-valid bits plus a last flag.
  - When the tail bit is 1, q_a is pushed into the output FIFO together with its last flag.
- Output FIFO:
  - Depth RD_LAT+1; first-word-fall-through.
  - pix_valid = !empty; pix_data/pix_last come from the head.
  - Pop occurs on pix_valid & pix_ready.
- Credit rule: issue only when (fifo_count + inflight) < RD_LAT+1, counting a same-cycle pop as freeing a slot. The FIFO therefore never overflows; an overflow condition is a bench assertion.
- Throughput: with pix_ready held high, one beat per clock. The first beat's pix_valid rises RD_LAT+1 cycles after the rd_start cycle.
- Address values: strictly 0,1,...,N-1 with no wrap. sel=0 gives N=1, a single beat with pix_last=1.
- rd_start while busy is ignored; no restart and no queuing. rd_start in the same cycle as done is accepted as a new burst.
- pix_ready low: the stream holds pix_data/pix_last stable while valid; issue stalls once credits are exhausted; no data is lost.
- rd_vga_addr holds its last value after the burst. The system guarantees the writer is idle while busy=1; the shared RAM port is not arbitrated here.

Decomposition:
- Package vga_pkg:
  - DW_PIX=24 and the FSM enum typedef rd_state_t {IDLE, ISSUE, DRAIN}.
  - Helper function burst_max(sel, MAW) returning N-1.
- Sub-module rd_skid_fifo (param DW+1 width, DEPTH): FWFT FIFO with count output, used for the output buffer.

Test Plan:
- Model the RAM as RD_LAT=2 with mem[i]=24'h100000+i. Apply sel=3 with pix_ready=1 and pulse rd_start. Required response:
  - Beats 24'h100000..24'h100007 on consecutive cycles.
  - First pix_valid 3 cycles after rd_start.
  - pix_last only on 24'h100007; done one cycle after it; busy spans the burst.
- sel=0 -> a single beat 24'h100000 with pix_last=1; done follows; rd_vga_addr only ever 0.
- sel=4, pix_ready toggling 1,0,0,1 repeatedly -> all 16 beats in order with no duplicates; data stable during ready=0; FIFO count never exceeds 3.
- sel=12 (clamped to MAW=10) -> exactly 1024 beats; last address 10'h3FF; no wrap to 0.
- Assert rst at beat 5 of a sel=4 burst -> outputs zero immediately (async). A new rd_start then yields a clean burst starting at 24'h100000.
- rd_start pulsed mid-burst -> ignored, with beat count unchanged. rd_start in the done cycle -> a second burst starts, with its first beat RD_LAT+1 cycles later.
